// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: buffers one sample per handshake, then steps a
// shared MAC through the taps using an external sample RAM and coefficient ROM.
module fir_tap_sequencer #(
    parameter int unsigned TAPS = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [AW:0]     num_taps,
    output logic            smp_we,
    output logic [AW-1:0]   smp_waddr,
    output logic [DW-1:0]   smp_wdata,
    output logic [AW-1:0]   smp_raddr,
    output logic [AW-1:0]   coef_addr,
    output logic            mac_clr,
    output logic            mac_en,
    input  logic [ACCW-1:0] acc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] TAPS_W = CW'(TAPS);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    state_t         state;
    logic [CW-1:0]  k;
    logic [CW-1:0]  neff;
    logic [AW-1:0]  wr_ptr;
    logic [DW-1:0]  sample_q;

    // k doubles as the INIT address counter, the tap index and the DRAIN cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            k        <= '0;
            neff     <= '0;
            wr_ptr   <= '0;
            sample_q <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            out_data <= '0;
        end else begin
            // MAC strobes trail the address phase by the RAM/ROM read latency
            mac_en  <= (state == MAC);
            mac_clr <= (state == MAC) && (k == '0);
            case (state)
                INIT: begin
                    if (k == CW'(TAPS - 1)) begin
                        k     <= '0;
                        state <= IDLE;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        sample_q <= in_data;
                        neff     <= (num_taps == '0 || num_taps > TAPS_W) ? TAPS_W : num_taps;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    if (k == neff - CW'(1)) begin
                        k      <= '0;
                        wr_ptr <= wr_ptr + AW'(1);
                        state  <= DRAIN;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                DRAIN: begin
                    if (k == CW'(1)) begin
                        k        <= '0;
                        out_data <= acc_in;
                        state    <= OUT;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Moore decodes of the state flops; held inactive while reset is asserted
    assign in_ready  = !reset && (state == IDLE);
    assign out_valid = !reset && (state == OUT);
    assign smp_we    = !reset && ((state == INIT) || (state == WRITE));
    assign busy      = (state != IDLE);

    assign smp_waddr = (state == INIT) ? k[AW-1:0] : wr_ptr;
    assign smp_wdata = (state == INIT) ? '0 : sample_q;
    assign smp_raddr = wr_ptr - k[AW-1:0];
    assign coef_addr = k[AW-1:0];

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: models the external RAM/ROM/MAC and checks results
// against a direct convolution over the sample history.
module tb_fir_tap_sequencer;

    localparam int unsigned TAPS = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned ACCW = 19;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [AW:0]     num_taps;
    logic            smp_we;
    logic [AW-1:0]   smp_waddr;
    logic [DW-1:0]   smp_wdata;
    logic [AW-1:0]   smp_raddr;
    logic [AW-1:0]   coef_addr;
    logic            mac_clr;
    logic            mac_en;
    logic [ACCW-1:0] acc_in;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic            busy;

    fir_tap_sequencer #(.TAPS(TAPS), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .num_taps  (num_taps),
        .smp_we    (smp_we),
        .smp_waddr (smp_waddr),
        .smp_wdata (smp_wdata),
        .smp_raddr (smp_raddr),
        .coef_addr (coef_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External datapath: sync-read sample RAM, sync-read coefficient ROM, MAC register
    logic [DW-1:0]   mem  [TAPS];
    logic [DW-1:0]   coef [TAPS];
    logic [DW-1:0]   ram_q;
    logic [DW-1:0]   rom_q;
    logic [ACCW-1:0] acc;

    always @(posedge clk) begin
        if (smp_we) mem[smp_waddr] <= smp_wdata;
        ram_q <= mem[smp_raddr];
        rom_q <= coef[coef_addr];
        if (mac_en) acc <= (mac_clr ? '0 : acc) + ACCW'(ram_q) * ACCW'(rom_q);
    end
    assign acc_in = acc;

    int n_cmp = 0;
    int n_bad = 0;

    // Observation log, refreshed each cycle by step()
    int            mac_cnt, clr_cnt, clr_pos, we_cnt;
    logic [AW-1:0] raddr_d;
    logic [AW-1:0] raddr_q [$];
    logic [AW-1:0] waddr_q [$];

    // Reference state: newest-first sample history since reset, and expected write slot
    int hist [$];
    int ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mac_en) begin
            mac_cnt++;
            raddr_q.push_back(raddr_d);
            if (mac_clr) begin
                clr_cnt++;
                clr_pos = mac_cnt;
            end
        end
        if (smp_we) begin
            we_cnt++;
            waddr_q.push_back(smp_waddr);
        end
        raddr_d = smp_raddr;
    endtask

    task automatic clear_log();
        mac_cnt = 0;
        clr_cnt = 0;
        clr_pos = 0;
        we_cnt  = 0;
        raddr_q.delete();
        waddr_q.delete();
    endtask

    task automatic reset_and_init();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_smp_we", 32'(smp_we), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_out_data", 32'(out_data), 0);
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < int'(TAPS); i++) begin
            check("init_busy", 32'(busy), 1);
            check("init_we", 32'(smp_we), 1);
            check("init_waddr", 32'(smp_waddr), 32'(i));
            check("init_wdata", 32'(smp_wdata), 0);
            check("init_in_ready", 32'(in_ready), 0);
            step();
        end
        check("idle_busy", 32'(busy), 0);
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);
        hist.delete();
        ptr = 0;
    endtask

    // One full transaction; bp > 0 holds out_ready low for bp cycles once the result shows
    task automatic run_sample(input int d, input int nt, input int bp);
        int n, exp, lat, guard, slot, we_before;
        logic [ACCW-1:0] held;
        n = (nt == 0 || nt > int'(TAPS)) ? int'(TAPS) : nt;
        in_valid  = 1'b1;
        in_data   = DW'(d);
        num_taps  = (AW+1)'(nt);
        out_ready = (bp == 0);
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("accept", 32'(in_ready), 1);
        clear_log();
        step();
        hist.push_front(d);
        if (hist.size() > int'(TAPS)) void'(hist.pop_back());
        exp = 0;
        for (int i = 0; i < n; i++)
            if (i < hist.size()) exp += int'(coef[i]) * hist[i];
        slot = ptr;
        ptr  = (ptr + 1) % int'(TAPS);
        // Inputs wiggled mid-operation must not disturb the current sample
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        num_taps = (AW+1)'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(n + 4));
        check("result", 32'(out_data), 32'(exp));
        check("mac_cycles", 32'(mac_cnt), 32'(n));
        check("clr_count", 32'(clr_cnt), 1);
        check("clr_first", 32'(clr_pos), 1);
        check("we_count", 32'(we_cnt), 1);
        if (waddr_q.size() > 0) check("waddr", 32'(waddr_q[0]), 32'(slot));
        for (int i = 0; i < n && i < raddr_q.size(); i++)
            check("raddr", 32'(raddr_q[i]), 32'((slot - i + int'(TAPS)) % int'(TAPS)));
        if (bp > 0) begin
            in_valid  = 1'b1;
            in_data   = DW'($urandom);
            we_before = we_cnt;
            for (int i = 0; i < bp; i++) begin
                held = out_data;
                step();
                check("bp_out_valid", 32'(out_valid), 1);
                check("bp_hold", 32'(out_data), 32'(held));
                check("bp_in_ready", 32'(in_ready), 0);
            end
            check("bp_no_write", 32'(we_cnt), 32'(we_before));
            out_ready = 1'b1;
        end
        step();
        in_valid = 1'b0;
        check("out_drop", 32'(out_valid), 0);
        check("back_idle", 32'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        num_taps  = '0;
        out_ready = 1'b1;
        raddr_d   = '0;
        clear_log();
        for (int i = 0; i < int'(TAPS); i++) coef[i] = DW'(i + 1);

        reset_and_init();

        // Impulse through four taps walks out the coefficients, then zero
        run_sample(1, 4, 0);
        check("impulse0", 32'(out_data), 1);
        run_sample(0, 4, 0);
        run_sample(0, 4, 0);
        run_sample(0, 4, 0);
        run_sample(0, 4, 0);

        // Long backpressure, then tap-count boundaries
        run_sample(200, 8, 20);
        run_sample(17, 0, 0);
        run_sample(99, 12, 0);
        run_sample(250, 1, 0);

        // Fresh start: ten full-length samples wrap the write pointer
        reset_and_init();
        for (int s = 0; s < 10; s++) run_sample(int'($urandom_range(0, 255)), 8, 0);

        // Random coefficients, data, tap counts and backpressure
        for (int i = 0; i < int'(TAPS); i++) coef[i] = DW'($urandom);
        for (int s = 0; s < 30; s++)
            run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)));

        // Reset in the middle of the MAC phase
        in_valid = 1'b1;
        in_data  = 8'd77;
        num_taps = 4'd8;
        begin
            int g;
            g = 0;
            while (!in_ready && g < 50) begin
                step();
                g++;
            end
            step();
            in_valid = 1'b0;
            step();
            step();
            step();
            reset = 1'b1;
            step();
            check("mid_rst_out_valid", 32'(out_valid), 0);
            check("mid_rst_mac_en", 32'(mac_en), 0);
            check("mid_rst_busy", 32'(busy), 1);
            reset = 1'b0;
            #1;
            g = 0;
            while (!in_ready && g < 30) begin
                step();
                g++;
            end
            check("mid_rst_init_len", 32'(g), 32'(TAPS));
        end
        hist.delete();
        ptr = 0;
        run_sample(5, 8, 0);
        run_sample(9, 3, 1);
        run_sample(int'($urandom_range(0, 255)), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Time-multiplexed FIR controller. Shares one external multiply-accumulate unit, one sample RAM and one coefficient ROM across all taps.
- Accepts one input sample per valid/ready handshake and writes it into a circular sample buffer.
- Then sequences one MAC operation per tap and presents the accumulator result on a valid/ready output.
- Sits between the pin-level I/O wrapper and the shared DSP datapath of the tile.

Parameters:
- TAPS, 8, maximum tap count and sample-buffer depth; power of two.
- AW, 3, address width, equal to log2(TAPS).
- DW, 8, sample width.
- ACCW, 19, accumulator/result width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  DW  input sample.
- num_taps  in  AW+1  active tap count; sampled at handshake.
- smp_we  out  1  sample RAM write enable.
- smp_waddr  out  AW  sample RAM write address.
- smp_wdata  out  DW  sample RAM write data.
- smp_raddr  out  AW  sample RAM read address; RAM read is synchronous, 1-cycle latency.
- coef_addr  out  AW  coefficient ROM address; ROM read is synchronous, 1-cycle latency.
- mac_clr  out  1  MAC loads product instead of adding.
- mac_en  out  1  MAC performs an operation this cycle.
- acc_in  in  ACCW  MAC accumulator value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACCW  filter result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: INIT, IDLE, WRITE, MAC, DRAIN, OUT.
- Reset (synchronous, wins over everything, including mid-operation):
  - state goes to INIT; wr_ptr=0, k=0.
  - in_ready=0, out_valid=0, out_data=0; smp_we, mac_en, mac_clr all 0.
  - Any in-flight sample or result is discarded.
- INIT:
  - Writes 0 to sample addresses 0..TAPS-1, one per cycle: smp_we=1, smp_waddr=k, smp_wdata=0.
  - Takes TAPS cycles, then goes to IDLE.
- IDLE:
  - in_ready=1. On in_valid&in_ready, latch in_data and neff, then go to WRITE.
  - neff = TAPS if num_taps is 0 or greater than TAPS; otherwise neff = num_taps.
- WRITE (1 cycle):
  - smp_we=1, smp_waddr=wr_ptr, smp_wdata=latched sample.
  - k=0, then go to MAC. The write is visible to reads from the next cycle.
- MAC (neff cycles, k = 0..neff-1):
  - smp_raddr = (wr_ptr - k) mod TAPS; coef_addr = k.
  - On leaving MAC, wr_ptr increments mod TAPS (wraps TAPS-1 to 0), then go to DRAIN.
- MAC control alignment:
  - mac_en and mac_clr are the MAC-phase address strobe delayed by one cycle, so they align with the read data.
  - mac_clr is high only on the cycle aligned with k=0.
- DRAIN (2 cycles): covers the read latency plus the MAC register.
  - At the end of the 2nd cycle, out_data <= acc_in; go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_valid&out_ready.
  - On that handshake, out_valid drops next cycle; go to IDLE.
  - Backpressure may last indefinitely; in_ready stays 0 throughout.
- Latency: handshake at cycle 0 → out_valid first high at cycle neff+4. Minimum sample period is neff+5 cycles (with out_ready held high).
- in_ready is high only in IDLE.
  - No new sample is accepted while a result is pending.
  - A sample is never overwritten before its result is taken.
- num_taps changes outside IDLE have no effect on the current sample.
- Tap ordering: k=0 multiplies the newest sample; k=neff-1 multiplies the sample neff-1 handshakes older.

Test Plan:
- Reset then idle: busy=1 for exactly 8 cycles with smp_we=1 and addresses 0..7, data 0; then in_ready=1, out_valid=0.
- Impulse, coefficients c[k]=k+1, num_taps=4, inputs 1,0,0,0,0 (out_ready=1): outputs 1,2,3,4,0; each out_valid appears 8 cycles after its handshake.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 → out_data stable, in_ready=0, no smp_we pulses; release → one result taken, next sample accepted in the IDLE cycle.
- Pointer wrap, num_taps=8, 10 samples → smp_waddr sequence 0..7,0,1; read addresses for sample 10 are 1,0,7,6,5,4,3,2.
- num_taps=0 and num_taps=12 each produce exactly 8 mac_en cycles; num_taps=1 produces 1 mac_en with mac_clr=1.
- Reset asserted during MAC phase → next cycle out_valid=0 and mac_en=0; INIT repeats; first post-reset result reflects only post-reset samples.
